// File: rtl/score_pkg.sv
// Shared constants and helpers for the BCD score counter.
// Optional feature macro: SCORE_HISCORE_EN (adds the high-score register).
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 16;
  localparam int MAX_W = BCD_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_ADD,
    OP_SUB
  } score_op_e;

  // Widest supported all-9s vector; callers slice off the digits they use.
  function automatic logic [MAX_W-1:0] bcd_max_vec(input int digits);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) v[i*BCD_W +: BCD_W] = BCD_MAX;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_score_counter_if.sv
// Pulse inputs and score outputs between the game FSM and the score counter.
// Optional feature macro: SCORE_HISCORE_EN (adds hi_digits).
interface bcd_score_counter_if
  import score_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                    clr;
  logic                    hit;
  logic                    penalty;
  logic [BCD_W*DIGITS-1:0] digits;
  logic                    at_max;
  logic                    changed;

`ifdef SCORE_HISCORE_EN
  logic [BCD_W*DIGITS-1:0] hi_digits;

  modport master (output clr, hit, penalty, input digits, at_max, changed, hi_digits);
  modport slave  (input clr, hit, penalty, output digits, at_max, changed, hi_digits);
`else
  modport master (output clr, hit, penalty, input digits, at_max, changed);
  modport slave  (input clr, hit, penalty, output digits, at_max, changed);
`endif

endinterface

// File: rtl/bcd_score_counter_digit.sv
// One combinational BCD digit slice: adds add+cin and subtracts bin, with
// decimal carry/borrow out. Used once per digit by bcd_score_counter.
module bcd_digit
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic [BCD_W-1:0] add,
  input  logic             cin,
  input  logic             bin,
  output logic [BCD_W-1:0] q,
  output logic             cout,
  output logic             bout
);

  logic [5:0] t;

  // t spans -1..19; a negative t wraps to 9 with borrow, t>9 wraps with carry.
  always_comb begin
    t    = {2'b00, d} + {2'b00, add} + {5'b0, cin} - {5'b0, bin};
    q    = t[3:0];
    cout = 1'b0;
    bout = 1'b0;
    if (t[5]) begin
      q    = t[3:0] + 4'd10;
      bout = 1'b1;
    end else if (t > 6'd9) begin
      q    = t[3:0] - 4'd10;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Saturating multi-digit BCD score counter (hits up, penalties down).
// Optional feature macro: SCORE_HISCORE_EN (tracks the high score in hi_digits).
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int STEP_UP = 1
) (
  input logic                clk,
  input logic                rst,
  bcd_score_counter_if.slave bus
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [MAX_W-1:0] MAX_FULL = bcd_max_vec(DIGITS);
  localparam logic [W-1:0] MAX_VEC = MAX_FULL[W-1:0];
  localparam logic [BCD_W-1:0] STEP = 4'(STEP_UP);

  score_op_e op;
  logic [W-1:0] score_q;
  logic [W-1:0] chain_q;
  logic [W-1:0] score_next;
  logic         at_max_q;
  logic         changed_q;

  always_comb begin
    op = OP_HOLD;
    if (bus.clr)                      op = OP_CLEAR;
    else if (bus.hit && !bus.penalty) op = OP_ADD;
    else if (bus.penalty && !bus.hit) op = OP_SUB;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic cin;
    logic bin;
    logic cout;
    logic bout;
    if (g == 0) begin : g_lsd
      assign cin = 1'b0;
      assign bin = (op == OP_SUB);
    end else begin : g_upper
      assign cin = g_digit[g-1].cout;
      assign bin = g_digit[g-1].bout;
    end
    bcd_digit u_digit (
      .d    (score_q[g*BCD_W +: BCD_W]),
      .add  ((g == 0 && op == OP_ADD) ? STEP : 4'd0),
      .cin  (cin),
      .bin  (bin),
      .q    (chain_q[g*BCD_W +: BCD_W]),
      .cout (cout),
      .bout (bout)
    );
  end

  // Carry out of the top digit saturates; borrow out of it means we were at 0.
  always_comb begin
    score_next = score_q;
    case (op)
      OP_CLEAR: score_next = '0;
      OP_ADD:   score_next = g_digit[DIGITS-1].cout ? MAX_VEC : chain_q;
      OP_SUB:   score_next = g_digit[DIGITS-1].bout ? score_q : chain_q;
      default:  score_next = score_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q   <= '0;
      at_max_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      score_q   <= score_next;
      at_max_q  <= (score_next == MAX_VEC);
      changed_q <= (score_next != score_q);
    end
  end

  assign bus.digits  = score_q;
  assign bus.at_max  = at_max_q;
  assign bus.changed = changed_q;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] hi_q;

  // Comparing against score_next keeps the high score on the same edge as digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
    end else if (score_next > hi_q) begin
      hi_q <= score_next;
    end
  end

  assign bus.hi_digits = hi_q;
`endif

endmodule

// File: tb/tb_bcd_score_counter.sv
// Self-checking bench for bcd_score_counter: directed scenarios plus random
// hit/penalty/clr traffic against an integer score model.
module tb_bcd_score_counter;
  import score_pkg::*;

  localparam int DIGITS    = 4;
  localparam int STEP_UP   = 1;
  localparam int W         = BCD_W * DIGITS;
  localparam int MAX_SCORE = 10 ** DIGITS - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_score_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_score_counter #(.DIGITS(DIGITS), .STEP_UP(STEP_UP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int score_m = 0;
  int hi_m = 0;
  bit changed_m = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i*BCD_W +: BCD_W] = 4'((n / (10 ** i)) % 10);
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic check_model();
    check_output("digits", 64'(bus.digits), 64'(to_bcd(score_m)));
    check_output("at_max", 64'(bus.at_max), 64'(score_m == MAX_SCORE));
    check_output("changed", 64'(bus.changed), 64'(changed_m));
    for (int i = 0; i < DIGITS; i++) begin
      check_output("digit_range", 64'(bus.digits[i*BCD_W +: BCD_W] <= 4'd9), 64'd1);
    end
`ifdef SCORE_HISCORE_EN
    check_output("hi_digits", 64'(bus.hi_digits), 64'(to_bcd(hi_m)));
    for (int i = 0; i < DIGITS; i++) begin
      check_output("hi_range", 64'(bus.hi_digits[i*BCD_W +: BCD_W] <= 4'd9), 64'd1);
    end
`endif
  endtask

  // One clock of stimulus; the model advances by the game's scoring rules.
  task automatic apply_stimulus(input bit c, input bit h, input bit p);
    int prev;
    bus.clr     = c;
    bus.hit     = h;
    bus.penalty = p;
    @(posedge clk);
    #1;
    prev = score_m;
    if (c)           score_m = 0;
    else if (h && p) score_m = score_m;
    else if (h)      score_m = (score_m + STEP_UP > MAX_SCORE) ? MAX_SCORE : score_m + STEP_UP;
    else if (p)      score_m = (score_m > 0) ? score_m - 1 : 0;
    changed_m = (score_m != prev);
    if (score_m > hi_m) hi_m = score_m;
    bus.clr     = 1'b0;
    bus.hit     = 1'b0;
    bus.penalty = 1'b0;
    check_model();
  endtask

  task automatic count_to(input int target);
    int guard;
    guard = 0;
    while (score_m < target && guard < 20000) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      guard++;
    end
    check_output("count_to", 64'(bus.digits), 64'(to_bcd(target)));
  endtask

  task automatic pulse_reset();
    #3;
    rst = 1'b1;
    #1;
    score_m   = 0;
    hi_m      = 0;
    changed_m = 1'b0;
    check_output("rst_digits", 64'(bus.digits), 64'h0);
    check_output("rst_at_max", 64'(bus.at_max), 64'h0);
    check_output("rst_changed", 64'(bus.changed), 64'h0);
`ifdef SCORE_HISCORE_EN
    check_output("rst_hi", 64'(bus.hi_digits), 64'h0);
`endif
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.hit     = 1'b0;
    bus.penalty = 1'b0;
    #2;
    check_model();
    #10;
    rst = 1'b0;

    count_to(42);
    pulse_reset();

    count_to(9);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s2_0010", 64'(bus.digits), 64'h0010);
    check_output("s2_changed", 64'(bus.changed), 64'd1);
    count_to(999);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("s2_1000", 64'(bus.digits), 64'h1000);

    count_to(9998);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("s3_9999", 64'(bus.digits), 64'h9999);
      check_output("s3_at_max", 64'(bus.at_max), 64'd1);
      check_output("s3_changed", 64'(bus.changed), (i == 0) ? 64'd1 : 64'd0);
    end

    apply_stimulus(1'b1, 1'b0, 1'b0);
    count_to(100);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("s4_0099", 64'(bus.digits), 64'h0099);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("s4_floor", 64'(bus.digits), 64'h0000);
    check_output("s4_changed", 64'(bus.changed), 64'd0);

    count_to(50);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("s5_both", 64'(bus.digits), 64'h0050);
    check_output("s5_changed", 64'(bus.changed), 64'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("s5_clr_hit", 64'(bus.digits), 64'h0000);

    pulse_reset();
    count_to(120);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    count_to(30);
`ifdef SCORE_HISCORE_EN
    check_output("s6_hi_held", 64'(bus.hi_digits), 64'h0120);
`endif
    count_to(121);
`ifdef SCORE_HISCORE_EN
    check_output("s6_hi_new", 64'(bus.hi_digits), 64'h0121);
`endif

    count_to(9990);
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 99) < 2,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
